// File: rtl/pla_seq_eval.sv
// Multi-cycle cube-table (PLA) evaluator: valid/ready operand in, CUBES_PER_CYC cubes per cycle, valid/ready result out.
// Optional build macro PLA_SEQ_EVAL_ESOP_EN switches the cube combine from OR (SOP) to XOR (ESOP).
module pla_seq_eval #(
    parameter int N_IN          = 16,
    parameter int N_OUT         = 1,
    parameter int N_CUBES       = 8,
    parameter int CUBES_PER_CYC = 2,
    localparam int AW           = (N_CUBES > 1) ? $clog2(N_CUBES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [N_IN-1:0]   cfg_care,
    input  logic [N_IN-1:0]   cfg_val,
    input  logic [N_OUT-1:0]  cfg_out,
    input  logic [N_OUT-1:0]  cfg_inv,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  y,
    output logic              busy
);

    localparam logic [AW-1:0] PTR_STEP = AW'(CUBES_PER_CYC);
    localparam logic [AW-1:0] PTR_LAST = AW'(N_CUBES - CUBES_PER_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [AW-1:0]      ptr_r;
    logic [N_IN-1:0]    x_r;
    logic [N_OUT-1:0]   acc_r;
    logic [N_OUT-1:0]   grp_s;
    logic [N_OUT-1:0]   y_r;
    logic [N_OUT-1:0]   inv_r;
    logic [N_IN-1:0]    care_r [N_CUBES];
    logic [N_IN-1:0]    val_r  [N_CUBES];
    logic [N_OUT-1:0]   out_r  [N_CUBES];
    logic               accept_s;
    logic               last_s;
    logic               cfg_wen_s;

    function automatic logic cube_match(input logic [N_IN-1:0] xv,
                                        input logic [N_IN-1:0] val,
                                        input logic [N_IN-1:0] care);
        return ((xv ^ val) & care) == {N_IN{1'b0}};
    endfunction

    assign accept_s  = (state_r == ST_IDLE) && in_valid;
    assign last_s    = (state_r == ST_EVAL) && (ptr_r == PTR_LAST);
    // The table is frozen while a scan is in flight so a result reflects one table image.
    assign cfg_wen_s = cfg_we && (state_r != ST_EVAL);

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);
    assign y         = y_r;

    // Fold the current cube group into the accumulator.
    always_comb begin : fold_group
        logic [AW-1:0]    idx;
        logic [N_OUT-1:0] hit;
        grp_s = acc_r;
        idx   = {AW{1'b0}};
        hit   = {N_OUT{1'b0}};
        for (int c = 0; c < CUBES_PER_CYC; c++) begin
            idx = ptr_r + AW'(c);
            hit = {N_OUT{cube_match(x_r, val_r[idx], care_r[idx])}} & out_r[idx];
`ifdef PLA_SEQ_EVAL_ESOP_EN
            grp_s = grp_s ^ hit;
`else
            grp_s = grp_s | hit;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_EVAL;
                else          state_s = ST_IDLE;
            end
            ST_EVAL: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_EVAL;
            end
            ST_DONE: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand capture, scan pointer, accumulator and held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r   <= {N_IN{1'b0}};
            ptr_r <= {AW{1'b0}};
            acc_r <= {N_OUT{1'b0}};
            y_r   <= {N_OUT{1'b0}};
        end else if (accept_s) begin
            x_r   <= x;
            ptr_r <= {AW{1'b0}};
            acc_r <= {N_OUT{1'b0}};
        end else if (state_r == ST_EVAL) begin
            acc_r <= grp_s;
            if (last_s) begin
                ptr_r <= {AW{1'b0}};
                y_r   <= inv_r ^ grp_s;
            end else begin
                ptr_r <= ptr_r + PTR_STEP;
            end
        end
    end

    // Cube table and output inversion; inversion is global and rewritten on every table write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CUBES; k++) begin
                care_r[k] <= {N_IN{1'b0}};
                val_r[k]  <= {N_IN{1'b0}};
                out_r[k]  <= {N_OUT{1'b0}};
            end
            inv_r <= {N_OUT{1'b0}};
        end else if (cfg_wen_s) begin
            care_r[cfg_addr] <= cfg_care;
            val_r[cfg_addr]  <= cfg_val;
            out_r[cfg_addr]  <= cfg_out;
            inv_r            <= cfg_inv;
        end
    end

endmodule

// File: tb/tb_pla_seq_eval.sv
// Self-checking bench for pla_seq_eval: directed scenarios plus randomized tables/operands against a cube-list model.
module tb_pla_seq_eval;

    localparam int N_IN  = 16;
    localparam int N_OUT = 1;
    localparam int NC    = 8;
    localparam int CPC   = 2;
    localparam int AW    = 3;
    localparam int E     = NC / CPC;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [AW-1:0]    cfg_addr = '0;
    logic [N_IN-1:0]  cfg_care = '0;
    logic [N_IN-1:0]  cfg_val = '0;
    logic [N_OUT-1:0] cfg_out = '0;
    logic [N_OUT-1:0] cfg_inv = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N_IN-1:0]  x = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N_OUT-1:0] y;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [N_IN-1:0]  m_care [NC];
    logic [N_IN-1:0]  m_val  [NC];
    logic [N_OUT-1:0] m_out  [NC];
    logic [N_OUT-1:0] m_inv;

    pla_seq_eval #(.N_IN(N_IN), .N_OUT(N_OUT), .N_CUBES(NC), .CUBES_PER_CYC(CPC)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_out(cfg_out), .cfg_inv(cfg_inv),
        .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NC; k++) begin
            m_care[k] = '0; m_val[k] = '0; m_out[k] = '0;
        end
        m_inv = '0;
    endtask

    // Each output: OR (or XOR in ESOP build) over the cubes that match x and feed it, then inverted.
    function automatic logic [N_OUT-1:0] ref_eval(input logic [N_IN-1:0] xv);
        logic [N_OUT-1:0] r;
        r = '0;
        for (int j = 0; j < N_OUT; j++) begin
            int hits;
            hits = 0;
            for (int k = 0; k < NC; k++)
                if (m_out[k][j] && ((xv & m_care[k]) == (m_val[k] & m_care[k]))) hits++;
`ifdef PLA_SEQ_EVAL_ESOP_EN
            r[j] = (hits % 2 == 1) ^ m_inv[j];
`else
            r[j] = (hits > 0) ^ m_inv[j];
`endif
        end
        return r;
    endfunction

    task automatic cfg_write(input int a, input logic [N_IN-1:0] c, input logic [N_IN-1:0] v,
                             input logic [N_OUT-1:0] o, input logic [N_OUT-1:0] inv);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_care = c; cfg_val = v; cfg_out = o; cfg_inv = inv;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_care[a] = c; m_val[a] = v; m_out[a] = o; m_inv = inv;
    endtask

    // One full transaction; eval_wr attempts a write of entry 7 during the first EVAL cycle.
    task automatic scan(input logic [N_IN-1:0] xv, input int hold, input bit eval_wr);
        logic [N_OUT-1:0] exp;
        int n;
        exp = ref_eval(xv);
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; x = xv;
        @(posedge clk); #1;
        in_valid = 1'b0; x = $urandom;
        check("busy_eval", busy, 1);
        for (int i = 0; i < E; i++) begin
            check("out_valid_early", out_valid, 0);
            check("in_ready_eval", in_ready, 0);
            if (eval_wr && i == 0) begin
                cfg_we = 1'b1; cfg_addr = 3'd7; cfg_care = '0; cfg_val = '0;
                cfg_out = 1'b1; cfg_inv = ~m_inv;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
        end
        check("out_valid_lat", out_valid, 1);
        check("y_result", y, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("y_hold", y, exp);
            check("in_ready_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("busy_drop", busy, 0);
    endtask

    initial begin
        logic [N_OUT-1:0] exp1, exp2;
        logic [N_IN-1:0]  xr;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_y", y, 0);
        @(posedge clk); #1;
        scan(16'hFFFF, 0, 1'b0);

        // Single cube behaving as y = x0
        cfg_write(0, 16'h0001, 16'h0000, 1'b1, 1'b1);
        scan(16'h0000, 0, 1'b0);
        scan(16'h0001, 1, 1'b0);

        // Overlapping cubes: OR keeps 1, ESOP cancels
        cfg_write(0, 16'h0003, 16'h0001, 1'b1, 1'b0);
        cfg_write(1, 16'h0001, 16'h0001, 1'b1, 1'b0);
        scan(16'h0001, 0, 1'b0);
        scan(16'h0003, 0, 1'b0);

        // Write to entry 7 during EVAL is ignored, same write in IDLE is used
        scan(16'h0002, 0, 1'b1);
        scan(16'h0002, 0, 1'b0);
        cfg_write(7, 16'h0000, 16'h0000, 1'b1, m_inv);
        scan(16'h0002, 0, 1'b0);

        // Backpressure with in_valid held high, plus a table write while DONE
        exp1 = ref_eval(16'h0001);
        in_valid = 1'b1; x = 16'h0001;
        @(posedge clk); #1;
        repeat (E) @(posedge clk);
        #1;
        check("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_y_stable", y, exp1);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid_hold", out_valid, 1);
            if (i == 4) begin
                cfg_we = 1'b1; cfg_addr = 3'd6; cfg_care = 16'h0001; cfg_val = 16'h0001;
                cfg_out = 1'b1; cfg_inv = 1'b1;
                m_care[6] = 16'h0001; m_val[6] = 16'h0001; m_out[6] = 1'b1; m_inv = 1'b1;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
        end
        check("bp_y_after_write", y, exp1);
        exp2 = ref_eval(16'h0001);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_no_same_cycle_accept", busy, 0);
        check("bp_in_ready_rise", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accept_next", busy, 1);
        repeat (E) @(posedge clk);
        #1;
        check("bp2_out_valid", out_valid, 1);
        check("bp2_y", y, exp2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset pulsed in the second EVAL cycle
        in_valid = 1'b1; x = 16'h0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_y", y, 0);
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("mid_rst_no_pulse", out_valid, 0);
        end
        scan(16'h0001, 0, 1'b0);
        scan(16'h5A5A, 0, 1'b0);

        // Randomized tables and operands
        for (int it = 0; it < 30; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                cfg_write($urandom_range(0, NC - 1), 16'($urandom) & 16'($urandom) & 16'($urandom),
                          16'($urandom), 1'($urandom), 1'($urandom));
            xr = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                xr = m_val[$urandom_range(0, NC - 1)] ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            scan(xr, $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
